pong_game_ctrl: RTL and testbench

Frame-rate game sequencer for the Pong design. It owns the game state machine, both paddle positions, ball position and velocity, and the score. It advances all game state once per video frame on a pulse from the `vga` timing block, and presents object coordinates to the pixel renderer. The left paddle is player-controlled from the board keys; the right paddle is computer-controlled and tracks the ball.

---
 rtl/pong_game_ctrl_if.sv | 25 ++
 rtl/pong_game_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_if.sv
// Pong game controller bus: frame tick, player controls and object coordinates.
// The master side is the board/vga side; the slave side is the game controller.
interface pong_game_ctrl_if;
    logic       i_frame_tick;
    logic       i_up;
    logic       i_dn;
    logic       i_start;
    logic [9:0] o_ball_x;
    logic [9:0] o_ball_y;
    logic [9:0] o_padl_y;
    logic [9:0] o_padr_y;
    logic [3:0] o_score_l;
    logic [3:0] o_score_r;
    logic [2:0] o_state;

    modport master (
        output i_frame_tick, i_up, i_dn, i_start,
        input  o_ball_x, o_ball_y, o_padl_y, o_padr_y, o_score_l, o_score_r, o_state
    );

    modport slave (
        input  i_frame_tick, i_up, i_dn, i_start,
        output o_ball_x, o_ball_y, o_padl_y, o_padr_y, o_score_l, o_score_r, o_state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong sequencer: game FSM, paddles, ball motion and scoring,
// all advanced on the per-frame tick from the vga timing block.
module pong_game_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PAD_W        = 8,
    parameter int PAD_H        = 64,
    parameter int BALL         = 8,
    parameter int PAD_XL       = 16,
    parameter int PAD_XR       = 616,
    parameter int PAD_SPD      = 4,
    parameter int CPU_SPD      = 3,
    parameter int BALL_SPD     = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic              CLOCK_50,
    input  logic              i_rst,
    pong_game_ctrl_if.slave   bus
);
    localparam int CW = $clog2(SERVE_FRAMES + 1);

    typedef logic signed [11:0] s12_t;

    localparam s12_t S0        = '0;
    localparam s12_t S_PAD_SPD = s12_t'(PAD_SPD);
    localparam s12_t S_CPU_SPD = s12_t'(CPU_SPD);
    localparam s12_t S_BSPD    = s12_t'(BALL_SPD);
    localparam s12_t S_BALL    = s12_t'(BALL);
    localparam s12_t S_HALF_B  = s12_t'(BALL / 2);
    localparam s12_t S_HALF_P  = s12_t'(PAD_H / 2);
    localparam s12_t S_PAD_H   = s12_t'(PAD_H);
    localparam s12_t S_PAD_W   = s12_t'(PAD_W);
    localparam s12_t S_XL      = s12_t'(PAD_XL);
    localparam s12_t S_XL_EDGE = s12_t'(PAD_XL + PAD_W);
    localparam s12_t S_XR      = s12_t'(PAD_XR);
    localparam s12_t S_HRES    = s12_t'(H_RES);
    localparam s12_t S_PAD_MAX = s12_t'(V_RES - PAD_H);
    localparam s12_t S_BALL_MY = s12_t'(V_RES - BALL);

    localparam logic [9:0]    CX         = 10'(H_RES / 2 - BALL / 2);
    localparam logic [9:0]    CY         = 10'(V_RES / 2 - BALL / 2);
    localparam logic [9:0]    PAD_Y0     = 10'(V_RES / 2 - PAD_H / 2);
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [9:0]    padl_q, padl_d, padr_q, padr_d;
    logic          dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d;
    logic          lscored_q, lscored_d;

    s12_t bx, by, pl, pr, pl_t, pr_t, diff, nx, ny;
    logic ndx, ndy, miss_l, miss_r;
    logic [3:0] score_inc;

    // Candidate next values; the FSM decides whether they are committed.
    always_comb begin
        bx   = s12_t'({2'b00, ball_x_q});
        by   = s12_t'({2'b00, ball_y_q});
        pl   = s12_t'({2'b00, padl_q});
        pr   = s12_t'({2'b00, padr_q});

        pl_t = pl;
        if (bus.i_up && !bus.i_dn)      pl_t = pl - S_PAD_SPD;
        else if (bus.i_dn && !bus.i_up) pl_t = pl + S_PAD_SPD;
        if (pl_t < S0)                  pl_t = S0;
        else if (pl_t > S_PAD_MAX)      pl_t = S_PAD_MAX;

        diff = (by + S_HALF_B) - (pr + S_HALF_P);
        pr_t = pr;
        if (diff >= S_CPU_SPD)          pr_t = pr + S_CPU_SPD;
        else if (diff <= -S_CPU_SPD)    pr_t = pr - S_CPU_SPD;
        if (pr_t < S0)                  pr_t = S0;
        else if (pr_t > S_PAD_MAX)      pr_t = S_PAD_MAX;

        nx  = dx_neg_q ? bx - S_BSPD : bx + S_BSPD;
        ny  = dy_neg_q ? by - S_BSPD : by + S_BSPD;
        ndx = dx_neg_q;
        ndy = dy_neg_q;

        // Wall reflection first so a corner hit sees the corrected row.
        if (ny < S0) begin
            ny  = S0;
            ndy = 1'b0;
        end else if (ny > S_BALL_MY) begin
            ny  = S_BALL_MY;
            ndy = 1'b1;
        end

        if (dx_neg_q && nx <= S_XL_EDGE && nx + S_BALL > S_XL &&
            ny + S_BALL > pl && ny < pl + S_PAD_H) begin
            nx  = S_XL_EDGE;
            ndx = 1'b0;
        end else if (!dx_neg_q && nx + S_BALL >= S_XR && nx < S_XR + S_PAD_W &&
                     ny + S_BALL > pr && ny < pr + S_PAD_H) begin
            nx  = S_XR - S_BALL;
            ndx = 1'b1;
        end

        miss_r = (nx <= S0);
        miss_l = (nx + S_BALL >= S_HRES);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        padl_d    = padl_q;
        padr_d    = padr_q;
        dx_neg_d  = dx_neg_q;
        dy_neg_d  = dy_neg_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        lscored_d = lscored_q;
        score_inc = (lscored_q ? score_l_q : score_r_q) + 4'd1;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d   = ST_SERVE;
                    score_l_d = '0;
                    score_r_d = '0;
                    cnt_d     = '0;
                end
            end
            ST_SERVE: begin
                if (bus.i_frame_tick) begin
                    padl_d = pl_t[9:0];
                    padr_d = pr_t[9:0];
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (bus.i_frame_tick) begin
                    padl_d = pl_t[9:0];
                    padr_d = pr_t[9:0];
                    if (miss_l || miss_r) begin
                        state_d   = ST_POINT;
                        lscored_d = miss_l;
                    end else begin
                        ball_x_d = nx[9:0];
                        ball_y_d = ny[9:0];
                        dx_neg_d = ndx;
                        dy_neg_d = ndy;
                    end
                end
            end
            ST_POINT: begin
                if (lscored_q) score_l_d = score_inc;
                else           score_r_d = score_inc;
                if (score_inc == WIN) begin
                    state_d = ST_OVER;
                end else begin
                    // Serve toward the player who just lost the point.
                    state_d  = ST_SERVE;
                    ball_x_d = CX;
                    ball_y_d = CY;
                    dx_neg_d = !lscored_q;
                end
            end
            ST_OVER: begin
                if (bus.i_start) begin
                    state_d   = ST_SERVE;
                    score_l_d = '0;
                    score_r_d = '0;
                    cnt_d     = '0;
                    ball_x_d  = CX;
                    ball_y_d  = CY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ball_x_q  <= CX;
            ball_y_q  <= CY;
            padl_q    <= PAD_Y0;
            padr_q    <= PAD_Y0;
            dx_neg_q  <= 1'b1;
            dy_neg_q  <= 1'b0;
            score_l_q <= '0;
            score_r_q <= '0;
            lscored_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            padl_q    <= padl_d;
            padr_q    <= padr_d;
            dx_neg_q  <= dx_neg_d;
            dy_neg_q  <= dy_neg_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            lscored_q <= lscored_d;
        end
    end

    assign bus.o_ball_x  = ball_x_q;
    assign bus.o_ball_y  = ball_y_q;
    assign bus.o_padl_y  = padl_q;
    assign bus.o_padr_y  = padr_q;
    assign bus.o_score_l = score_l_q;
    assign bus.o_score_r = score_r_q;
    assign bus.o_state   = state_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: reset, serve timing, paddle clamp,
// left-paddle hit, miss/score and game-over sequences.
module tb_pong_game_ctrl;
    logic CLOCK_50 = 1'b0;
    logic i_rst    = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    pong_game_ctrl_if bus();

    pong_game_ctrl #(
        .H_RES(640), .V_RES(480), .PAD_W(8), .PAD_H(64), .BALL(8),
        .PAD_XL(16), .PAD_XR(616), .PAD_SPD(4), .CPU_SPD(3), .BALL_SPD(2),
        .SERVE_FRAMES(60), .WIN_SCORE(9)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .i_rst    (i_rst),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(negedge CLOCK_50) bus.i_frame_tick = 1'b1;
        @(negedge CLOCK_50) bus.i_frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLOCK_50) bus.i_start = 1'b1;
        @(negedge CLOCK_50) bus.i_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50) i_rst = 1'b1;
        @(negedge CLOCK_50) i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; bus.i_frame_tick = 1'b1; bus.i_start = 1'b1; bus.i_up = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if (bus.o_state !== 3'd0) begin
            errors++; $display("FAIL rst_overrides_start: state got %0d expected 0", bus.o_state);
        end
        i_rst = 1'b0; bus.i_frame_tick = 1'b0; bus.i_start = 1'b0; bus.i_up = 1'b0;
        @(negedge CLOCK_50);
        checks++;
        if (bus.o_ball_x !== 10'd316) begin
            errors++; $display("FAIL rst_ball_x: got %0d expected 316", bus.o_ball_x);
        end
        checks++;
        if (bus.o_ball_y !== 10'd236) begin
            errors++; $display("FAIL rst_ball_y: got %0d expected 236", bus.o_ball_y);
        end
        checks++;
        if (bus.o_padl_y !== 10'd208 || bus.o_padr_y !== 10'd208) begin
            errors++; $display("FAIL rst_paddles: got %0d/%0d expected 208/208", bus.o_padl_y, bus.o_padr_y);
        end
        checks++;
        if (bus.o_score_l !== 4'd0 || bus.o_score_r !== 4'd0) begin
            errors++; $display("FAIL rst_scores: got %0d/%0d expected 0/0", bus.o_score_l, bus.o_score_r);
        end
        checks++;
        if (bus.o_state !== 3'd0) begin
            errors++; $display("FAIL rst_state: got %0d expected 0", bus.o_state);
        end
    endtask

    task automatic test_serve_timing();
        do_reset();
        pulse_start();
        checks++;
        if (bus.o_state !== 3'd1) begin
            errors++; $display("FAIL start_to_serve: state got %0d expected 1", bus.o_state);
        end
        for (int k = 1; k <= 59; k++) begin
            tick();
            checks++;
            if (bus.o_state !== 3'd1) begin
                errors++; $display("FAIL serve_hold tick %0d: state got %0d expected 1", k, bus.o_state);
            end
        end
        tick();
        checks++;
        if (bus.o_state !== 3'd2) begin
            errors++; $display("FAIL serve_launch: state got %0d expected 2", bus.o_state);
        end
        checks++;
        if (bus.o_ball_x !== 10'd316 || bus.o_ball_y !== 10'd236) begin
            errors++; $display("FAIL serve_ball_held: got (%0d,%0d) expected (316,236)", bus.o_ball_x, bus.o_ball_y);
        end
        tick();
        checks++;
        if (bus.o_ball_x !== 10'd314 || bus.o_ball_y !== 10'd238) begin
            errors++; $display("FAIL first_move: got (%0d,%0d) expected (314,238)", bus.o_ball_x, bus.o_ball_y);
        end
        pulse_start();
        checks++;
        if (bus.o_state !== 3'd2) begin
            errors++; $display("FAIL start_ignored_play: state got %0d expected 2", bus.o_state);
        end
    endtask

    task automatic test_paddle_clamp();
        logic [9:0] exp_y;
        do_reset();
        pulse_start();
        bus.i_up = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            exp_y = (208 - 4 * k > 0) ? 10'(208 - 4 * k) : 10'd0;
            checks++;
            if (bus.o_padl_y !== exp_y) begin
                errors++; $display("FAIL padl_up tick %0d: got %0d expected %0d", k, bus.o_padl_y, exp_y);
            end
        end
        bus.i_dn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.o_padl_y !== 10'd0) begin
                errors++; $display("FAIL padl_both_hold: got %0d expected 0", bus.o_padl_y);
            end
        end
        bus.i_up = 1'b0;
        tick();
        checks++;
        if (bus.o_padl_y !== 10'd4) begin
            errors++; $display("FAIL padl_down: got %0d expected 4", bus.o_padl_y);
        end
        bus.i_dn = 1'b0;
    endtask

    task automatic test_left_hit();
        do_reset();
        pulse_start();
        bus.i_dn = 1'b1;
        repeat (60) tick();
        repeat (145) tick();
        checks++;
        if (bus.o_ball_x !== 10'd26 || bus.o_ball_y !== 10'd420) begin
            errors++; $display("FAIL pre_hit_ball: got (%0d,%0d) expected (26,420)", bus.o_ball_x, bus.o_ball_y);
        end
        checks++;
        if (bus.o_padl_y !== 10'd416) begin
            errors++; $display("FAIL pre_hit_padl: got %0d expected 416", bus.o_padl_y);
        end
        tick();
        checks++;
        if (bus.o_ball_x !== 10'd24 || bus.o_ball_y !== 10'd418) begin
            errors++; $display("FAIL hit_ball: got (%0d,%0d) expected (24,418)", bus.o_ball_x, bus.o_ball_y);
        end
        checks++;
        if (bus.o_state !== 3'd2 || bus.o_score_l !== 4'd0 || bus.o_score_r !== 4'd0) begin
            errors++; $display("FAIL hit_no_score: state/scores got %0d/%0d/%0d expected 2/0/0",
                               bus.o_state, bus.o_score_l, bus.o_score_r);
        end
        tick();
        checks++;
        if (bus.o_ball_x !== 10'd26 || bus.o_ball_y !== 10'd416) begin
            errors++; $display("FAIL post_hit_ball: got (%0d,%0d) expected (26,416)", bus.o_ball_x, bus.o_ball_y);
        end
        bus.i_dn = 1'b0;
    endtask

    task automatic test_miss();
        int n;
        do_reset();
        pulse_start();
        bus.i_up = 1'b1;
        repeat (60) tick();
        n = 0;
        while (n < 200 && bus.o_state !== 3'd3) begin
            tick();
            n++;
        end
        checks++;
        if (n != 158) begin
            errors++; $display("FAIL miss_tick_count: got %0d expected 158", n);
        end
        checks++;
        if (bus.o_ball_x !== 10'd2 || bus.o_ball_y !== 10'd396) begin
            errors++; $display("FAIL miss_ball_frozen: got (%0d,%0d) expected (2,396)", bus.o_ball_x, bus.o_ball_y);
        end
        // A tick during POINT must not advance the serve counter or paddles.
        bus.i_frame_tick = 1'b1;
        @(negedge CLOCK_50) bus.i_frame_tick = 1'b0;
        checks++;
        if (bus.o_state !== 3'd1) begin
            errors++; $display("FAIL point_one_cycle: state got %0d expected 1", bus.o_state);
        end
        checks++;
        if (bus.o_score_r !== 4'd1 || bus.o_score_l !== 4'd0) begin
            errors++; $display("FAIL miss_score: got l=%0d r=%0d expected l=0 r=1", bus.o_score_l, bus.o_score_r);
        end
        checks++;
        if (bus.o_ball_x !== 10'd316 || bus.o_ball_y !== 10'd236) begin
            errors++; $display("FAIL miss_recentre: got (%0d,%0d) expected (316,236)", bus.o_ball_x, bus.o_ball_y);
        end
        checks++;
        if (bus.o_padl_y !== 10'd0) begin
            errors++; $display("FAIL point_tick_padl: got %0d expected 0", bus.o_padl_y);
        end
    endtask

    task automatic test_game_over();
        int n;
        for (int r = 2; r <= 9; r++) begin
            bus.i_up = (r % 2) == 1;
            bus.i_dn = (r % 2) == 0;
            repeat (60) tick();
            checks++;
            if (bus.o_state !== 3'd2) begin
                errors++; $display("FAIL round %0d launch: state got %0d expected 2", r, bus.o_state);
            end
            n = 0;
            while (n < 200 && bus.o_state !== 3'd3) begin
                tick();
                n++;
            end
            checks++;
            if (n != 158) begin
                errors++; $display("FAIL round %0d miss_ticks: got %0d expected 158", r, n);
            end
            checks++;
            if (bus.o_ball_x !== 10'd2 || bus.o_ball_y !== ((r % 2) == 1 ? 10'd396 : 10'd76)) begin
                errors++; $display("FAIL round %0d miss_ball: got (%0d,%0d) expected (2,%0d)",
                                   r, bus.o_ball_x, bus.o_ball_y, (r % 2) == 1 ? 396 : 76);
            end
            @(negedge CLOCK_50);
            checks++;
            if (bus.o_state !== (r == 9 ? 3'd4 : 3'd1) || bus.o_score_r !== 4'(r) || bus.o_score_l !== 4'd0) begin
                errors++; $display("FAIL round %0d after_point: state=%0d l=%0d r=%0d expected state=%0d l=0 r=%0d",
                                   r, bus.o_state, bus.o_score_l, bus.o_score_r, r == 9 ? 4 : 1, r);
            end
        end
        bus.i_up = 1'b0;
        bus.i_dn = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.o_state !== 3'd4 || bus.o_score_r !== 4'd9) begin
            errors++; $display("FAIL over_hold: state=%0d r=%0d expected 4/9", bus.o_state, bus.o_score_r);
        end
        checks++;
        if (bus.o_ball_x !== 10'd2 || bus.o_ball_y !== 10'd396 || bus.o_padl_y !== 10'd0) begin
            errors++; $display("FAIL over_frozen: ball (%0d,%0d) padl %0d expected (2,396) padl 0",
                               bus.o_ball_x, bus.o_ball_y, bus.o_padl_y);
        end
        bus.i_dn = 1'b0;
        pulse_start();
        checks++;
        if (bus.o_state !== 3'd1 || bus.o_score_l !== 4'd0 || bus.o_score_r !== 4'd0) begin
            errors++; $display("FAIL restart: state=%0d l=%0d r=%0d expected 1/0/0",
                               bus.o_state, bus.o_score_l, bus.o_score_r);
        end
        checks++;
        if (bus.o_ball_x !== 10'd316 || bus.o_ball_y !== 10'd236) begin
            errors++; $display("FAIL restart_ball: got (%0d,%0d) expected (316,236)", bus.o_ball_x, bus.o_ball_y);
        end
    endtask

    initial begin
        bus.i_frame_tick = 1'b0;
        bus.i_up         = 1'b0;
        bus.i_dn         = 1'b0;
        bus.i_start      = 1'b0;
        test_reset();
        test_serve_timing();
        test_paddle_clamp();
        test_left_hit();
        test_miss();
        test_game_over();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
